// File: rtl/ai_sort_scheduler_pkg.sv
// Shared definitions for the sorter-sharing scheduler: FSM states, width helper.
package ai_sort_scheduler_pkg;

  localparam int unsigned DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_LOAD = 2'd2,
    S_RUN  = 2'd3
  } state_e;

  // Bits needed to hold values 0..v-1 (minimum 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/ai_rr_pick.sv
// Combinational round-robin selector: one-hot first requester after ptr_i (wrapping).
module ai_rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o
);

  // Scan from ptr+1 upwards, wrapping; the first set request wins.
  always_comb begin
    int unsigned idx;
    logic        found;
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr_i) + k) % NREQ;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ai_sort_scheduler.sv
// Shares one sorter between NREQ requesters: round-robin grant, init pulse,
// SIZE-word load, tagged return of sorted words, and a stall watchdog.
module ai_sort_scheduler
  import ai_sort_scheduler_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned SIZE = 8,
  parameter int unsigned DW   = DW_DEFAULT,
  parameter int unsigned TMO  = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  output logic [NREQ-1:0]    grant,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  output logic               srt_init,
  output logic [DW-1:0]      srt_data,
  output logic               srt_rdy,
  input  logic [DW-1:0]      srt_out,
  input  logic               srt_out_rdy,
  input  logic               srt_done,
  output logic [DW-1:0]      res_data,
  output logic [NREQ-1:0]    res_valid,
  output logic               res_last,
  output logic               busy,
  output logic               tmo_err
);

  localparam int unsigned PW = clog2(NREQ);
  localparam int unsigned CW = clog2(SIZE + 1);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     load_cnt_q, load_cnt_d;
  logic [CW-1:0]     out_cnt_q, out_cnt_d;
  logic [7:0]        wd_q, wd_d;
  logic [DW-1:0]     res_data_q, res_data_d;
  logic [NREQ-1:0]   res_valid_q, res_valid_d;
  logic              res_last_q, res_last_d;
  logic              tmo_err_q, tmo_err_d;
  logic              srt_init_q, srt_init_d;

  logic [NREQ-1:0]   pick_gnt;
  logic [PW-1:0]     gidx;
  logic [DW-1:0]     g_data;
  logic              g_valid;
  logic              load_phase;

  ai_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt)
  );

  // Decode the owner index and select its word/valid.
  always_comb begin
    gidx    = '0;
    g_data  = '0;
    g_valid = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        gidx    = PW'(i);
        g_data  = req_data[i*DW +: DW];
        g_valid = req_valid[i];
      end
    end
  end

  assign load_phase = (state_q == S_LOAD);
  assign req_ready  = load_phase ? (grant_q & req_valid) : '0;
  assign srt_rdy    = load_phase & g_valid;
  assign srt_data   = load_phase ? g_data : '0;

  assign grant      = grant_q;
  assign res_data   = res_data_q;
  assign res_valid  = res_valid_q;
  assign res_last   = res_last_q;
  assign tmo_err    = tmo_err_q;
  assign srt_init   = srt_init_q;
  assign busy       = (state_q != S_IDLE);

  // Next-state, counters and registered result path.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    load_cnt_d  = load_cnt_q;
    out_cnt_d   = out_cnt_q;
    wd_d        = wd_q;
    res_data_d  = res_data_q;
    res_valid_d = '0;
    res_last_d  = 1'b0;
    tmo_err_d   = 1'b0;
    srt_init_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d    = pick_gnt;
          srt_init_d = 1'b1;
          state_d    = S_INIT;
        end
      end
      S_INIT: begin
        load_cnt_d = '0;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        if (srt_rdy) begin
          if (load_cnt_q == CW'(SIZE - 1)) begin
            load_cnt_d = '0;
            out_cnt_d  = '0;
            wd_d       = '0;
            state_d    = S_RUN;
          end else begin
            load_cnt_d = load_cnt_q + CW'(1);
          end
        end
      end
      S_RUN: begin
        if (srt_out_rdy) begin
          res_data_d  = srt_out;
          res_valid_d = grant_q;
          out_cnt_d   = out_cnt_q + CW'(1);
          wd_d        = '0;
          if (srt_done || (out_cnt_q == CW'(SIZE - 1))) begin
            res_last_d = 1'b1;
            ptr_d      = gidx;
            grant_d    = '0;
            state_d    = S_IDLE;
          end
        end else if (wd_q == 8'(TMO)) begin
          // Abort re-inits the sorter and still rotates priority away from the owner.
          tmo_err_d  = 1'b1;
          srt_init_d = 1'b1;
          ptr_d      = gidx;
          grant_d    = '0;
          state_d    = S_IDLE;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      ptr_q       <= PW'(NREQ - 1);
      load_cnt_q  <= '0;
      out_cnt_q   <= '0;
      wd_q        <= '0;
      res_data_q  <= '0;
      res_valid_q <= '0;
      res_last_q  <= 1'b0;
      tmo_err_q   <= 1'b0;
      srt_init_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      load_cnt_q  <= load_cnt_d;
      out_cnt_q   <= out_cnt_d;
      wd_q        <= wd_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
      tmo_err_q   <= tmo_err_d;
      srt_init_q  <= srt_init_d;
    end
  end

endmodule

// File: doc/ai_sort_scheduler.md
# ai_sort_scheduler

Controller that shares one `AI_sorter` instance between `NREQ` requesters, such as several `AI_collector` channels or comparer lanes. It grants the sorter to one requester at a time in round-robin order and issues the sorter `init` pulse. It streams exactly `SIZE` words from the granted requester into the sorter, then routes the `SIZE` ascending-ordered results back with a one-hot tag. A watchdog recovers the shared sorter if it stalls.

## Interface
- `NREQ`, 2 — number of requesters (2..8).
- `SIZE`, 8 — words per sort batch; must equal the sorter depth.
- `DW`, 32 — data word width.
- `TMO`, 255 — max idle cycles between sorter outputs before abort (fits 8-bit counter).
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `req`  in  NREQ  — requester i wants a sort batch; level, held until its `res_last`.
- `grant`  out  NREQ  — one-hot owner of the sorter; registered.
- `req_data`  in  NREQ*DW  — word from requester i at bits `[i*DW +: DW]`.
- `req_valid`  in  NREQ  — word valid.
- `req_ready`  out  NREQ  — word accepted this cycle.
- `srt_init`  out  1  — sorter init pulse.
- `srt_data`  out  DW  — to sorter `data_in`.
- `srt_rdy`  out  1  — to sorter `data_rdy`.
- `srt_out`  in  DW  — from sorter `data_out`.
- `srt_out_rdy`  in  1  — from sorter `data_out_rdy`.
- `srt_done`  in  1  — from sorter `sort_ready`.
- `res_data`  out  DW  — sorted word; registered.
- `res_valid`  out  NREQ  — one-hot tag of the destination requester.
- `res_last`  out  1  — final word of the batch.
- `busy`  out  1  — state ≠ IDLE.
- `tmo_err`  out  1  — one-cycle pulse on watchdog abort.

## Operation
- Reset values: all outputs 0, state IDLE, round-robin pointer = NREQ-1, so requester 0 wins first.
- States:
  - IDLE: if any `req`, pick the first set bit searching from pointer+1 (wrapping), register `grant`, go to INIT.
  - INIT: assert `srt_init` for exactly one cycle; no data is sent. Go to LOAD.
  - LOAD: `req_ready[g] = req_valid[g]`, `srt_rdy = req_valid[g]`, `srt_data = req_data[g]`; these are combinational pass-throughs. Each accepted word increments `load_cnt`. When the SIZE-th word is accepted, go to RUN. Gaps in `req_valid` are allowed.
  - RUN: on each `srt_out_rdy`, register `res_data = srt_out` and `res_valid = grant`, then increment `out_cnt`. If `srt_done` is high in the same cycle as an output, or `out_cnt` reaches SIZE, assert `res_last` with that word, set pointer = g, clear `grant`, and go to IDLE.
- Watchdog: the counter is cleared on every accepted output and on entry to RUN. If it reaches TMO in RUN: pulse `tmo_err`, pulse `srt_init`, drop `grant` without `res_last`, go to IDLE. The pointer still advances, so the faulty requester loses priority.
- `req` deasserted after grant is ignored; the batch completes. `req` asserted by the current owner at `res_last` is re-arbitrated normally, so another pending requester wins.
- `req_ready` is 0 for every non-granted requester at all times.
- Async reset mid-batch: everything returns to reset values immediately. The sorter is re-initialised by the next INIT.

## Timing
- Grant latency: `req` high in cycle t gives `grant` at t+1, `srt_init` at t+1 (INIT), and the first possible `req_ready` at t+2.
- Load: SIZE cycles minimum with `req_valid` held high.
- Sorter: SIZE+1 cycles per output. The first `res_valid` comes 1 cycle after `srt_out_rdy`.
- Back-to-back batches: IDLE→INIT overhead is 2 cycles after `res_last`.
- Minimum total for a SIZE=8 batch with the real sorter: 1 + 1 + 8 + 72 + 1 cycles.

## Structure
- Shared package: state encoding (IDLE/INIT/LOAD/RUN), `clog2` helper for counter widths, `DW` default.
- One natural sub-module: `ai_rr_pick`, a combinational round-robin one-hot selector taking `req` and the pointer.
- Datapath mux and counters live in the top.

## Test plan
- One requester, keys (low 24 bits) 5,3,9,1,7,2,8,4 → `res_valid=01` eight times with 1,2,3,4,5,7,8,9; `res_last` on 9.
- `req=11` asserted together → requester 0 batch completes, then requester 1; grant order 01,10,01 over three batches with `req` held.
- `req_valid` toggling 1,0,1,0 during LOAD → exactly 8 words reach the sorter; results are unchanged.
- Sorter model stops emitting after 3 outputs → `tmo_err` pulse at TMO+1 cycles after the last output, `srt_init` pulse, `grant=0`, `busy=0`.
- `rst` low during RUN → all outputs 0 asynchronously; next batch after release sorts correctly.
- `req[0]` dropped mid-LOAD → batch still loads 8 words and returns 8 results.
